// File: rtl/ddr3_burst_pkg.sv
// Shared types and constants for the DDR3 burst writer/reader pair.
package ddr3_burst_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        REQ,
        DATA,
        HALT
    } state_t;

    // Defaults shared with the writer so both sides target the same region.
    localparam logic [7:0]  DEF_BURSTCNT = 8'h80;
    localparam logic [28:0] DEF_ADDRESS  = 29'h2400000;

    // The writer stores the beat index in the low byte of each word.
    function automatic logic [31:0] expected_word(input logic [7:0] beat_idx);
        return {24'b0, beat_idx};
    endfunction

endpackage

// File: rtl/ddr3_burst_reader_if.sv
// DDRAM Avalon-MM read channel as seen by the burst reader.
interface ddr3_burst_reader_if;
    logic        DDRAM_BUSY;
    logic        DDRAM_RD;
    logic [28:0] DDRAM_ADDR;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;

    modport master (
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT
    );

    modport slave (
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT
    );
endinterface

// File: rtl/ddr3_beat_checker.sv
// Per-beat compare, saturating error counter and first-error capture.
module ddr3_beat_checker
    import ddr3_burst_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [7:0]  beat_idx_i,
    input  logic [31:0] data_i,
    input  logic        extra_err_i,
    output logic [15:0] err_cnt_o,
    output logic        first_err_valid_o,
    output logic [7:0]  first_err_beat_o,
    output logic [31:0] first_err_data_o
);

    logic [15:0] err_cnt_q;
    logic        fv_q;
    logic [7:0]  fbeat_q;
    logic [31:0] fdata_q;
    logic        mismatch;

    assign mismatch = valid_i && (data_i != expected_word(beat_idx_i));

    // Count mismatches (plus any external error event) and latch the first bad beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            fv_q      <= 1'b0;
            fbeat_q   <= '0;
            fdata_q   <= '0;
        end else begin
            if ((mismatch || extra_err_i) && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
            if (mismatch && !fv_q) begin
                fv_q    <= 1'b1;
                fbeat_q <= beat_idx_i;
                fdata_q <= data_i;
            end
        end
    end

    assign err_cnt_o         = err_cnt_q;
    assign first_err_valid_o = fv_q;
    assign first_err_beat_o  = fbeat_q;
    assign first_err_data_o  = fdata_q;

endmodule

// File: rtl/ddr3_burst_reader.sv
// Back-to-back DDR3 burst reader that checks each beat against the writer's pattern.
// Optional read watchdog enabled by defining DDR3_READ_TIMEOUT_EN.
module ddr3_burst_reader
    import ddr3_burst_pkg::*;
#(
    parameter logic [7:0]  BURSTCNT = DEF_BURSTCNT,
    parameter logic [28:0] ADDRESS  = DEF_ADDRESS,
    parameter int          WAIT_W   = 10
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                safe_stop,
    input  logic [WAIT_W-1:0]   wait_max,
    ddr3_burst_reader_if.master bus,
    output logic                active,
    output logic [15:0]         burst_done,
    output logic [15:0]         err_cnt,
    output logic                first_err_valid,
    output logic [7:0]          first_err_beat,
    output logic [31:0]         first_err_data
`ifdef DDR3_READ_TIMEOUT_EN
    ,
    output logic                timeout
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_ONE  = 1;
    localparam logic [7:0]        LAST_BEAT = BURSTCNT - 8'd1;

    state_t              state_q;
    logic [WAIT_W-1:0]   wait_q;
    logic [7:0]          beat_q;
    logic                rd_q;
    logic [28:0]         addr_q;
    logic [7:0]          bcnt_q;
    logic [15:0]         burst_q;
    logic                beat_vld;
    logic                extra_err;
    logic                unused_hi;

    // Upper half of the data bus carries nothing: the writer only enables the low 4 bytes.
    assign unused_hi = ^bus.DDRAM_DOUT[63:32];

    // Beats are only checked in DATA; the acceptance cycle is still REQ so it is never sampled.
    assign beat_vld = (state_q == DATA) && bus.DDRAM_DOUT_READY;

`ifdef DDR3_READ_TIMEOUT_EN
    logic [15:0] wdog_q;
    logic        timeout_q;
    assign extra_err = (state_q == DATA) && !bus.DDRAM_DOUT_READY && (wdog_q == 16'hFFFF);
    assign timeout   = timeout_q;
`else
    assign extra_err = 1'b0;
`endif

    // Control FSM: gap timer, request hold under waitrequest, beat counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            bcnt_q  <= '0;
            burst_q <= '0;
`ifdef DDR3_READ_TIMEOUT_EN
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= GAP;
                        wait_q  <= '0;
                    end
                end
                GAP: begin
                    if (safe_stop)
                        state_q <= HALT;
                    else if (!start)
                        state_q <= IDLE;
                    else if (wait_q == wait_max) begin
                        state_q <= REQ;
                        rd_q    <= 1'b1;
                        addr_q  <= ADDRESS;
                        bcnt_q  <= BURSTCNT;
                    end else
                        wait_q <= wait_q + WAIT_ONE;
                end
                REQ: begin
                    // RD/ADDR/BURSTCNT stay put until waitrequest drops.
                    if (!bus.DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        state_q <= DATA;
                        beat_q  <= '0;
`ifdef DDR3_READ_TIMEOUT_EN
                        wdog_q  <= '0;
`endif
                    end
                end
                DATA: begin
                    if (bus.DDRAM_DOUT_READY) begin
                        beat_q <= beat_q + 8'd1;
`ifdef DDR3_READ_TIMEOUT_EN
                        wdog_q <= '0;
`endif
                        if (beat_q == LAST_BEAT) begin
                            burst_q <= burst_q + 16'd1;
                            if (safe_stop)
                                state_q <= HALT;
                            else if (start) begin
                                state_q <= GAP;
                                wait_q  <= '0;
                            end else
                                state_q <= IDLE;
                        end
                    end
`ifdef DDR3_READ_TIMEOUT_EN
                    else if (wdog_q == 16'hFFFF) begin
                        timeout_q <= 1'b1;
                        state_q   <= HALT;
                    end else
                        wdog_q <= wdog_q + 16'd1;
`endif
                end
                HALT:    rd_q <= 1'b0;
                default: state_q <= IDLE;
            endcase
        end
    end

    ddr3_beat_checker u_chk (
        .clk               (clk),
        .rst_n             (reset_n),
        .valid_i           (beat_vld),
        .beat_idx_i        (beat_q),
        .data_i            (bus.DDRAM_DOUT[31:0]),
        .extra_err_i       (extra_err),
        .err_cnt_o         (err_cnt),
        .first_err_valid_o (first_err_valid),
        .first_err_beat_o  (first_err_beat),
        .first_err_data_o  (first_err_data)
    );

    assign bus.DDRAM_RD       = rd_q;
    assign bus.DDRAM_ADDR     = addr_q;
    assign bus.DDRAM_BURSTCNT = bcnt_q;
    assign burst_done         = burst_q;
    assign active             = (state_q == GAP) || (state_q == REQ) || (state_q == DATA);

endmodule

// File: tb/tb_ddr3_burst_reader.sv
// Self-checking bench for ddr3_burst_reader (BURSTCNT=4).
module tb_ddr3_burst_reader;

    localparam int WAIT_W = 10;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              safe_stop;
    logic [WAIT_W-1:0] wait_max;
    logic              active;
    logic [15:0]       burst_done;
    logic [15:0]       err_cnt;
    logic              first_err_valid;
    logic [7:0]        first_err_beat;
    logic [31:0]       first_err_data;
`ifdef DDR3_READ_TIMEOUT_EN
    logic              timeout;
`endif

    ddr3_burst_reader_if bus();

    ddr3_burst_reader #(
        .BURSTCNT (8'd4),
        .ADDRESS  (29'h2400000),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .safe_stop       (safe_stop),
        .wait_max        (wait_max),
        .bus             (bus.master),
        .active          (active),
        .burst_done      (burst_done),
        .err_cnt         (err_cnt),
        .first_err_valid (first_err_valid),
        .first_err_beat  (first_err_beat),
        .first_err_data  (first_err_data)
`ifdef DDR3_READ_TIMEOUT_EN
        ,
        .timeout         (timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int accept_cnt = 0;

    // Count accepted requests as the memory side sees them.
    always @(posedge clk) begin
        if (reset_n && bus.DDRAM_RD && !bus.DDRAM_BUSY)
            accept_cnt <= accept_cnt + 1;
    end

    // Reference model state: what the counters should read, derived from beats delivered.
    logic [15:0] exp_err;
    logic [15:0] exp_done;
    logic        exp_fv;
    logic [7:0]  exp_fbeat;
    logic [31:0] exp_fdata;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_err = 0; exp_done = 0; exp_fv = 0; exp_fbeat = 0; exp_fdata = 0;
    endtask

    task automatic model_beat(input int b, input logic [63:0] d);
        if (d[31:0] != 32'(b)) begin
            if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            if (!exp_fv) begin
                exp_fv = 1'b1; exp_fbeat = 8'(b); exp_fdata = d[31:0];
            end
        end
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_done"},  64'(burst_done),      64'(exp_done));
        chk({tag, "_err"},   64'(err_cnt),         64'(exp_err));
        chk({tag, "_fv"},    64'(first_err_valid), 64'(exp_fv));
        chk({tag, "_fbeat"}, 64'(first_err_beat),  64'(exp_fbeat));
        chk({tag, "_fdata"}, 64'(first_err_data),  64'(exp_fdata));
    endtask

    // Wait for a request, stall it busy_n cycles, accept, then deliver 4 beats.
    // Called and returning on a negedge. BUSY idles high so follow-on requests wait.
    task automatic do_burst(input int busy_n, input logic [3:0][63:0] beats,
                            input int stop_beat, input int max_gap);
        int n;
        int acc0;
        n = 0;
        while (!bus.DDRAM_RD && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rd_seen", 64'(bus.DDRAM_RD), 64'd1);
        if (!bus.DDRAM_RD) return;
        chk("req_addr", 64'(bus.DDRAM_ADDR), 64'h2400000);
        chk("req_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'd4);
        acc0 = accept_cnt;
        for (int i = 0; i < busy_n; i++) begin
            // Stray read data while the request stalls must be ignored.
            bus.DDRAM_DOUT_READY = 1'b1;
            bus.DDRAM_DOUT = {$urandom, $urandom};
            @(negedge clk);
            chk("busy_rd",   64'(bus.DDRAM_RD), 64'd1);
            chk("busy_addr", 64'(bus.DDRAM_ADDR), 64'h2400000);
            chk("busy_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'd4);
        end
        bus.DDRAM_DOUT_READY = 1'b0;
        bus.DDRAM_BUSY = 1'b0;
        @(negedge clk);
        bus.DDRAM_BUSY = 1'b1;
        chk("acc_rd_low", 64'(bus.DDRAM_RD), 64'd0);
        chk("accept_once", 64'(accept_cnt - acc0), 64'd1);
        for (int b = 0; b < 4; b++) begin
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
            bus.DDRAM_DOUT_READY = 1'b1;
            bus.DDRAM_DOUT = beats[b];
            if (b == stop_beat) safe_stop = 1'b1;
            model_beat(b, beats[b]);
            @(negedge clk);
            bus.DDRAM_DOUT_READY = 1'b0;
        end
        exp_done = exp_done + 16'd1;
    endtask

    typedef struct {
        int          busy_n;
        logic [3:0]  bad;
        logic [31:0] badval;
        logic [31:0] hi;
        logic [15:0] exp_err;
        logic        exp_fv;
        logic [7:0]  exp_fbeat;
        logic [31:0] exp_fdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [3:0][63:0] beats;
        int n;
        int rd_seen;

        // Cumulative expectations: each row continues from the previous one.
        vecs[0] = '{0, 4'b0000, 32'h0,        32'h0,        16'd0, 1'b0, 8'd0, 32'h0};
        vecs[1] = '{5, 4'b0000, 32'h0,        32'hFFFFFFFF, 16'd0, 1'b0, 8'd0, 32'h0};
        vecs[2] = '{1, 4'b0100, 32'hDEAD0002, 32'h0,        16'd1, 1'b1, 8'd2, 32'hDEAD0002};
        vecs[3] = '{0, 4'b1000, 32'hDEAD0003, 32'h12345678, 16'd2, 1'b1, 8'd2, 32'hDEAD0002};
        vecs[4] = '{2, 4'b1111, 32'h00000100, 32'h0,        16'd6, 1'b1, 8'd2, 32'hDEAD0002};
        vecs[5] = '{3, 4'b0000, 32'h0,        32'hA5A5A5A5, 16'd6, 1'b1, 8'd2, 32'hDEAD0002};

        reset_n = 1'b0; start = 1'b0; safe_stop = 1'b0; wait_max = '0;
        bus.DDRAM_BUSY = 1'b1; bus.DDRAM_DOUT = '0; bus.DDRAM_DOUT_READY = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_rd",   64'(bus.DDRAM_RD), 64'd0);
        chk("rst_addr", 64'(bus.DDRAM_ADDR), 64'd0);
        chk("rst_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'd0);
        chk("rst_active", 64'(active), 64'd0);
        check_stats("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // Latency: RD rises wait_max+1 cycles after the edge that samples start.
        wait_max = 10'd3;
        start = 1'b1;
        n = 0;
        while (!bus.DDRAM_RD && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("lat_cycles", 64'(n), 64'd5);
        chk("lat_active", 64'(active), 64'd1);

        // Table-driven bursts.
        for (int v = 0; v < 6; v++) begin
            for (int b = 0; b < 4; b++)
                beats[b] = vecs[v].bad[b] ? {vecs[v].hi, vecs[v].badval}
                                          : {vecs[v].hi, 24'b0, 8'(b)};
            do_burst(vecs[v].busy_n, beats, -1, 0);
            chk("vec_err",   64'(err_cnt),         64'(vecs[v].exp_err));
            chk("vec_fv",    64'(first_err_valid), 64'(vecs[v].exp_fv));
            chk("vec_fbeat", 64'(first_err_beat),  64'(vecs[v].exp_fbeat));
            chk("vec_fdata", 64'(first_err_data),  64'(vecs[v].exp_fdata));
            chk("vec_done",  64'(burst_done),      64'(v + 1));
            chk("vec_active", 64'(active),         64'd1);
        end

        // Randomised bursts against the model.
        for (int r = 0; r < 20; r++) begin
            for (int b = 0; b < 4; b++)
                beats[b] = ($urandom_range(2, 0) != 0) ? {$urandom, 32'(b)}
                                                       : {$urandom, 32'($urandom_range(7, 0))};
            do_burst($urandom_range(4, 0), beats, -1, 2);
            check_stats("rnd");
        end

        // safe_stop on beat 1: burst completes, then HALT ignores start.
        for (int b = 0; b < 4; b++) beats[b] = {32'h0, 32'(b)};
        do_burst(0, beats, 1, 1);
        check_stats("stop");
        chk("stop_active", 64'(active), 64'd0);
        bus.DDRAM_BUSY = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 20; i++) begin
            start = i[1];
            safe_stop = i[2];
            @(negedge clk);
            if (bus.DDRAM_RD) rd_seen++;
        end
        chk("halt_no_rd", 64'(rd_seen), 64'd0);
        chk("halt_active", 64'(active), 64'd0);
        bus.DDRAM_BUSY = 1'b1;
        safe_stop = 1'b0;

        // Reset mid-burst: asynchronous clear, stray beats afterwards ignored.
        start = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        n = 0;
        while (!bus.DDRAM_RD && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.DDRAM_BUSY = 1'b0;
        @(negedge clk);
        bus.DDRAM_BUSY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.DDRAM_DOUT_READY = 1'b1;
            bus.DDRAM_DOUT = {32'h0, 32'(b)};
            @(negedge clk);
        end
        chk("mid_active", 64'(active), 64'd1);
        bus.DDRAM_DOUT = 64'hFFFF_FFFF_BAD0_0002;
        #1 reset_n = 1'b0;
        start = 1'b0;
        #1;
        chk("arst_rd",     64'(bus.DDRAM_RD), 64'd0);
        chk("arst_addr",   64'(bus.DDRAM_ADDR), 64'd0);
        chk("arst_bcnt",   64'(bus.DDRAM_BURSTCNT), 64'd0);
        chk("arst_active", 64'(active), 64'd0);
        check_stats("arst");
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.DDRAM_DOUT = {$urandom, 32'hBAD0_0000 | 32'(i)};
            @(negedge clk);
        end
        bus.DDRAM_DOUT_READY = 1'b0;
        check_stats("stray");
        chk("stray_active", 64'(active), 64'd0);

`ifdef DDR3_READ_TIMEOUT_EN
        // Memory stops after beat 1: watchdog must fire, count one error and halt.
        chk("to_init", 64'(timeout), 64'd0);
        start = 1'b1;
        n = 0;
        while (!bus.DDRAM_RD && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.DDRAM_BUSY = 1'b0;
        @(negedge clk);
        bus.DDRAM_BUSY = 1'b1;
        for (int b = 0; b < 2; b++) begin
            bus.DDRAM_DOUT_READY = 1'b1;
            bus.DDRAM_DOUT = {32'h0, 32'(b)};
            @(negedge clk);
        end
        bus.DDRAM_DOUT_READY = 1'b0;
        n = 0;
        while (active && n < 70000) begin
            @(negedge clk);
            n++;
        end
        chk("to_wait_bound", 64'(n >= 65535 && n < 70000), 64'd1);
        chk("to_flag",   64'(timeout), 64'd1);
        chk("to_err",    64'(err_cnt), 64'd1);
        chk("to_active", 64'(active), 64'd0);
        chk("to_done",   64'(burst_done), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_burst_reader.md
Name: ddr3_burst_reader

Overview:
- Read-side counterpart to the DDR3 burst write tester.
- Issues back-to-back burst reads on the DDRAM Avalon-MM read channel and checks each beat against the pattern the writer stores.
- Counts bursts, beats and mismatches, and captures the first failing beat for OSD/LED readout.
- Sits in the clk_ddr3 domain, next to the writer, between emu control bits and the DDRAM port.

Parameters:
- BURSTCNT, 8'h80, beats per read burst (1..255).
- ADDRESS, 29'h2400000, DDRAM word address of every burst.
- WAIT_W, 10, width of the inter-burst gap counter.

Ports:
- clk  in  1  DDR3-side clock (clk_ddr3).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; 1 enables issuing bursts.
- safe_stop  in  1  level; finish the in-flight burst, then halt.
- wait_max  in  WAIT_W  idle cycles between bursts.
- DDRAM_BUSY  in  1  waitrequest.
- DDRAM_RD  out  1  read request.
- DDRAM_ADDR  out  29  burst address.
- DDRAM_BURSTCNT  out  8  burst length.
- DDRAM_DOUT  in  64  read data.
- DDRAM_DOUT_READY  in  1  read-data valid.
- active  out  1  1 while not in IDLE/HALT.
- burst_done  out  16  completed-burst counter (wraps).
- err_cnt  out  16  mismatched-beat counter (saturates at 16'hFFFF).
- first_err_valid  out  1  sticky: a mismatch has been captured.
- first_err_beat  out  8  beat index of the first mismatch.
- first_err_data  out  32  DOUT[31:0] of the first mismatch.

Behaviour:
- Reset (reset_n=0, async): state=IDLE; DDRAM_RD=0, DDRAM_ADDR=0, DDRAM_BURSTCNT=0; all counters, captures and flags 0.
- States:
  - IDLE: start=1 -> GAP, with the wait counter cleared.
  - GAP: count up; when count==wait_max -> REQ. wait_max=0 gives one GAP cycle.
    - safe_stop=1 here -> HALT.
    - start=0 here -> IDLE.
  - REQ: DDRAM_RD=1, ADDR=ADDRESS, BURSTCNT=BURSTCNT. All three are held stable while DDRAM_BUSY=1.
    - Accepted on the first cycle with DDRAM_BUSY=0; next cycle RD=0 and state -> DATA, with the beat index cleared.
    - Only one burst is ever outstanding.
  - DATA: on each DOUT_READY cycle, compare DOUT[31:0] to {24'b0, beat_idx[7:0]}. DOUT[63:32] is ignored because the writer uses BE=8'h0F.
    - Mismatch: err_cnt += 1 (saturating). If first_err_valid=0, capture beat_idx and data and set first_err_valid.
    - Increment beat_idx on each DOUT_READY cycle.
    - On the beat with beat_idx==BURSTCNT-1: burst_done += 1; then HALT if safe_stop=1, GAP if start=1, else IDLE.
  - HALT: terminal. DDRAM_RD=0. Left only by reset.
- Boundary cases:
  - start dropping in REQ/DATA does not abort; the burst completes.
  - safe_stop asserted in REQ is acted on only after the burst's last beat.
  - DOUT_READY outside DATA is ignored and is not counted as an error.
  - DOUT_READY in the same cycle as acceptance is impossible per protocol; the block does not sample it.
  - Reset mid-burst: outputs return to reset values immediately. Late returning beats are ignored (state IDLE).
- Latency: first RD assertion occurs wait_max+1 cycles after start is sampled in IDLE.
- active: 1 in GAP, REQ and DATA.

Optional Feature:
- Macro DDR3_READ_TIMEOUT_EN.
- When defined: a 16-bit watchdog counts clocks in DATA without DOUT_READY and resets on each beat.
  - At 16'hFFFF the block sets output timeout (sticky, reset 0), increments err_cnt once, and goes to HALT.
  - The timeout port exists only when the macro is defined.
- When undefined: no watchdog; DATA waits indefinitely.

Decomposition:
- Package ddr3_burst_pkg holds:
  - state enum (IDLE, GAP, REQ, DATA, HALT);
  - default BURSTCNT/ADDRESS constants, shared with the writer;
  - pattern function expected_word(beat_idx), returning 32 bits.
- One sub-module, ddr3_beat_checker: compare, saturating err_cnt and first-error capture. Inputs: valid, beat_idx, data. Outputs: error stats.

Test Plan:
- Clean read, BURSTCNT=4, wait_max=0, BUSY=0, memory model returns 0,1,2,3: one RD pulse with ADDR=29'h2400000, BURSTCNT=4; after 4 beats burst_done=1, err_cnt=0, state GAP.
- BUSY held high for 5 cycles during REQ: RD/ADDR/BURSTCNT stable all 5 cycles; exactly one request accepted when BUSY drops.
- Beat 2 returns 32'hDEAD0002: err_cnt=1, first_err_beat=2, first_err_data=32'hDEAD0002. A second bad beat 3 gives err_cnt=2 with capture unchanged.
- safe_stop asserted mid-DATA (beat 1 of 4): remaining beats are consumed, burst_done increments, state HALT, no further RD; start toggling has no effect.
- reset_n pulled low on beat 2: all outputs 0 asynchronously. Stray DOUT_READY beats after release leave err_cnt=0.
- DDR3_READ_TIMEOUT_EN defined, memory model stops after beat 1: after 65535 idle cycles timeout=1, err_cnt=1, state HALT.
